// File: rtl/wb_regfile.sv
// wb_regfile: write-back stage register file.
// Selects write-back data (load data or ALU result), commits it to a
// 2^ADDR_W x DATA_W register file with r0 hardwired to zero, and serves two
// combinational ID-stage read ports, one debug read port and a retired-write
// counter.
// Optional feature: define WB_BYPASS_EN to give ports A and B a same-cycle
// write-through bypass. The debug port is never bypassed.
module wb_regfile #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int CNT_W  = 32
) (
   input  logic              clk,
   input  logic              clrn,
   input  logic              wb_wreg,
   input  logic              wb_m2reg,
   input  logic [DATA_W-1:0] wb_mo,
   input  logic [DATA_W-1:0] wb_alu,
   input  logic [ADDR_W-1:0] wb_rn,
   input  logic [ADDR_W-1:0] rna,
   input  logic [ADDR_W-1:0] rnb,
   output logic [DATA_W-1:0] qa,
   output logic [DATA_W-1:0] qb,
   input  logic [ADDR_W-1:0] dbg_rn,
   output logic [DATA_W-1:0] dbg_q,
   output logic [CNT_W-1:0]  wb_cnt
);

   localparam int DEPTH = 1 << ADDR_W;
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [DATA_W-1:0] r_regs [DEPTH];
   logic [CNT_W-1:0]  r_cnt;

   logic [DATA_W-1:0] w_wdata;
   logic              w_commit;
   logic [DATA_W-1:0] w_rd_a;
   logic [DATA_W-1:0] w_rd_b;

   // wb_m2reg only matters when a write actually commits.
   assign w_wdata  = wb_m2reg ? wb_mo : wb_alu;
   // Writes to r0 are dropped entirely: no state change, no count.
   assign w_commit = wb_wreg && (wb_rn != '0);

   // Commit the selected write-back data and count every retired write.
   // NOTE: the whole array is cleared by clrn so no read can ever return X;
   // that costs a reset net on every flop, so this stays a flop array
   // rather than a RAM macro. All state here uses <= so every read in the
   // same edge sees pre-edge values.
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_regs[i] <= '0;
         end
         r_cnt <= '0;
      end else if (w_commit) begin
         r_regs[wb_rn] <= w_wdata;
         r_cnt         <= r_cnt + CNT_ONE;
      end
   end

   // Stored-contents reads; index 0 is forced to zero on every port.
   assign w_rd_a = (rna == '0)    ? '0 : r_regs[rna];
   assign w_rd_b = (rnb == '0)    ? '0 : r_regs[rnb];
   assign dbg_q  = (dbg_rn == '0) ? '0 : r_regs[dbg_rn];

`ifdef WB_BYPASS_EN
   logic w_byp_a;
   logic w_byp_b;

   // w_commit already excludes r0, so index 0 can never be bypassed.
   // Bypass is held off while clrn is low so reset reads are always zero.
   assign w_byp_a = clrn && w_commit && (wb_rn == rna);
   assign w_byp_b = clrn && w_commit && (wb_rn == rnb);
   assign qa      = w_byp_a ? w_wdata : w_rd_a;
   assign qb      = w_byp_b ? w_wdata : w_rd_b;
`else
   // No bypass: the old value stays visible until the commit edge and
   // the hazard unit stalls one cycle instead.
   assign qa = w_rd_a;
   assign qb = w_rd_b;
`endif

   assign wb_cnt = r_cnt;

endmodule

// File: tb/tb_wb_regfile.sv
// tb_wb_regfile: directed self-checking bench for wb_regfile.
// A second instance with CNT_W=4 shares all inputs and is used for the
// counter wrap checks. Bypass-dependent expectations follow WB_BYPASS_EN.
module tb_wb_regfile;

   logic        clk = 1'b0;
   logic        clrn;
   logic        wb_wreg;
   logic        wb_m2reg;
   logic [31:0] wb_mo;
   logic [31:0] wb_alu;
   logic [4:0]  wb_rn;
   logic [4:0]  rna;
   logic [4:0]  rnb;
   logic [4:0]  dbg_rn;
   logic [31:0] qa;
   logic [31:0] qb;
   logic [31:0] dbg_q;
   logic [31:0] wb_cnt;
   logic [31:0] qa4;
   logic [31:0] qb4;
   logic [31:0] dbg_q4;
   logic [3:0]  wb_cnt4;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   wb_regfile #(.DATA_W(32), .ADDR_W(5), .CNT_W(32)) u_dut (
      .clk(clk), .clrn(clrn), .wb_wreg(wb_wreg), .wb_m2reg(wb_m2reg),
      .wb_mo(wb_mo), .wb_alu(wb_alu), .wb_rn(wb_rn), .rna(rna), .rnb(rnb),
      .qa(qa), .qb(qb), .dbg_rn(dbg_rn), .dbg_q(dbg_q), .wb_cnt(wb_cnt)
   );

   wb_regfile #(.DATA_W(32), .ADDR_W(5), .CNT_W(4)) u_dut4 (
      .clk(clk), .clrn(clrn), .wb_wreg(wb_wreg), .wb_m2reg(wb_m2reg),
      .wb_mo(wb_mo), .wb_alu(wb_alu), .wb_rn(wb_rn), .rna(rna), .rnb(rnb),
      .qa(qa4), .qb(qb4), .dbg_rn(dbg_rn), .dbg_q(dbg_q4), .wb_cnt(wb_cnt4)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Advance past one rising edge and settle, away from the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [4:0] rn, input logic [31:0] alu,
                     input logic [31:0] mo, input logic m2);
      wb_rn    = rn;
      wb_alu   = alu;
      wb_mo    = mo;
      wb_m2reg = m2;
      wb_wreg  = 1'b1;
      tick();
      wb_wreg  = 1'b0;
   endtask

   initial begin
      clrn = 1'b0; wb_wreg = 1'b0; wb_m2reg = 1'b0; wb_mo = '0; wb_alu = '0;
      wb_rn = '0; rna = 5'd5; rnb = 5'd7; dbg_rn = 5'd31;

      // Reset state
      #2;
      check("rst_qa", qa, 32'h0);
      check("rst_qb", qb, 32'h0);
      check("rst_dbg", dbg_q, 32'h0);
      check("rst_cnt", wb_cnt, 32'h0);
      repeat (2) @(posedge clk);
      #2 clrn = 1'b1;

      // ALU vs memory select
      wr(5'd7, 32'hDEADBEEF, 32'h11111111, 1'b0);
      dbg_rn = 5'd7;
      #1 check("sel_alu", dbg_q, 32'hDEADBEEF);
      wr(5'd7, 32'hDEADBEEF, 32'h11111111, 1'b1);
      #1 check("sel_mem", dbg_q, 32'h11111111);
      check("sel_cnt", wb_cnt, 32'd2);

      // r0 protection over three edges, including the bypass path
      wb_rn = 5'd0; wb_alu = 32'hFFFFFFFF; wb_m2reg = 1'b0; wb_wreg = 1'b1;
      rna = 5'd0; rnb = 5'd0; dbg_rn = 5'd0;
      #1;
      check("r0_qa_pre", qa, 32'h0);
      check("r0_qb_pre", qb, 32'h0);
      repeat (3) tick();
      wb_wreg = 1'b0;
      check("r0_qa", qa, 32'h0);
      check("r0_qb", qb, 32'h0);
      check("r0_dbg", dbg_q, 32'h0);
      check("r0_cnt", wb_cnt, 32'd2);

      // Read-during-write to the same index
      wr(5'd9, 32'h0000000A, 32'h0, 1'b0);
      wb_rn = 5'd9; wb_alu = 32'h0000000B; wb_m2reg = 1'b0; wb_wreg = 1'b1;
      rna = 5'd9; rnb = 5'd9; dbg_rn = 5'd9;
      #1;
`ifdef WB_BYPASS_EN
      check("rdw_qa_pre", qa, 32'hB);
      check("rdw_qb_pre", qb, 32'hB);
`else
      check("rdw_qa_pre", qa, 32'hA);
      check("rdw_qb_pre", qb, 32'hA);
`endif
      check("rdw_dbg_pre", dbg_q, 32'hA);
      tick();
      wb_wreg = 1'b0;
      check("rdw_qa_post", qa, 32'hB);
      check("rdw_qb_post", qb, 32'hB);
      check("rdw_dbg_post", dbg_q, 32'hB);
      check("rdw_cnt", wb_cnt, 32'd4);

      // wb_wreg=0 gating: no write, no count, no bypass
      wr(5'd3, 32'h00000077, 32'h0, 1'b0);
      wb_rn = 5'd3; wb_alu = 32'h55; wb_mo = 32'h66; wb_m2reg = 1'b1; wb_wreg = 1'b0;
      rna = 5'd3; rnb = 5'd3; dbg_rn = 5'd3;
      #1 check("gate_qa_pre", qa, 32'h77);
      repeat (4) tick();
      check("gate_qa", qa, 32'h77);
      check("gate_dbg", dbg_q, 32'h77);
      check("gate_cnt", wb_cnt, 32'd5);

      // Mid-run reset after r5=0x1234 with three writes retired
      clrn = 1'b0;
      #2 clrn = 1'b1;
      wr(5'd1, 32'h1, 32'h0, 1'b0);
      wr(5'd2, 32'h2, 32'h0, 1'b0);
      wr(5'd5, 32'h1234, 32'h0, 1'b0);
      rna = 5'd5; rnb = 5'd5; dbg_rn = 5'd5;
      #1;
      check("mr_pre_qa", qa, 32'h1234);
      check("mr_pre_cnt", wb_cnt, 32'd3);
      wb_rn = 5'd5; wb_alu = 32'h9999; wb_m2reg = 1'b0; wb_wreg = 1'b1;
      clrn = 1'b0;
      #1;
      check("mr_qa", qa, 32'h0);
      check("mr_qb", qb, 32'h0);
      check("mr_dbg", dbg_q, 32'h0);
      check("mr_cnt", wb_cnt, 32'h0);
      check("mr_cnt4", {28'h0, wb_cnt4}, 32'h0);
      tick();
      check("mr_hold_qa", qa, 32'h0);
      wb_wreg = 1'b0;
      clrn = 1'b1;
      tick();
      dbg_rn = 5'd1;
      #1;
      check("mr_after_qa", qa, 32'h0);
      check("mr_after_r1", dbg_q, 32'h0);
      check("mr_after_cnt", wb_cnt, 32'h0);

      // Counter wrap on the CNT_W=4 instance; release right before a write
      // so the first edge with clrn=1 commits normally.
      clrn = 1'b0;
      wb_rn = 5'd1; wb_alu = 32'h101; wb_m2reg = 1'b0; wb_wreg = 1'b1;
      #2 clrn = 1'b1;
      for (int i = 1; i <= 17; i++) begin
         wb_rn  = 5'(i);
         wb_alu = 32'h100 + 32'(i);
         tick();
         if (i == 1)  check("wrap_first", wb_cnt, 32'd1);
         if (i == 15) check("wrap_cnt4_f", {28'h0, wb_cnt4}, 32'hF);
         if (i == 16) check("wrap_cnt4_0", {28'h0, wb_cnt4}, 32'h0);
      end
      wb_wreg = 1'b0;
      dbg_rn = 5'd17;
      #1;
      check("wrap_cnt4_end", {28'h0, wb_cnt4}, 32'd1);
      check("wrap_cnt32_end", wb_cnt, 32'd17);
      check("wrap_r17", dbg_q, 32'h111);
      dbg_rn = 5'd1;
      #1 check("wrap_r1", dbg_q, 32'h101);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Write-back end of the MEM/WB pipeline register: the consumer of wb_wreg, wb_m2reg, wb_mo, wb_alu, wb_rn.
- Selects the write-back data (memory output or ALU result) and commits it to a 2^ADDR_W x DATA_W general-purpose register file.
- Provides two asynchronous read ports for the ID stage and one debug read port.
- Keeps a retired-write counter for bring-up and performance checks.

Parameters:
DATA_W, 32, register and data width in bits
ADDR_W, 5, register index width; the file holds 2^ADDR_W registers
CNT_W, 32, width of the retired-write counter

Ports:
clk  input  1  clock; all state updates on rising edge
clrn  input  1  asynchronous active-low reset
wb_wreg  input  1  write enable from MEM/WB register
wb_m2reg  input  1  1 = write wb_mo, 0 = write wb_alu
wb_mo  input  DATA_W  memory load data
wb_alu  input  DATA_W  ALU result
wb_rn  input  ADDR_W  destination register index
rna  input  ADDR_W  read port A index (rs)
rnb  input  ADDR_W  read port B index (rt)
qa  output  DATA_W  read port A data
qb  output  DATA_W  read port B data
dbg_rn  input  ADDR_W  debug read index
dbg_q  output  DATA_W  debug read data, never bypassed
wb_cnt  output  CNT_W  count of committed register writes

Behaviour:
- Reset: clk and clrn as already decided. clrn=0 asynchronously clears all registers r0..r(2^ADDR_W-1) to 0 and wb_cnt to 0.
  - During reset, qa, qb and dbg_q read 0 for every index.
  - Bypass is suppressed while clrn=0.
  - Reset deasserting mid-stream: the first edge with clrn=1 performs a normal write.
- Write data: wdata = wb_m2reg ? wb_mo : wb_alu. This is combinational. wb_m2reg is ignored when wb_wreg=0.
- Commit: on posedge clk with clrn=1, wb_wreg=1 and wb_rn!=0:
  - r[wb_rn] <= wdata
  - wb_cnt <= wb_cnt+1
- r0 is hardwired zero:
  - A write with wb_rn=0 changes no state and does not increment wb_cnt.
  - Any read of index 0 returns 0 on every port, including the bypass path.
- Reads are combinational, with zero cycle latency:
  - qa = (rna==0) ? 0 : r[rna]
  - qb = (rnb==0) ? 0 : r[rnb]
  - dbg_q = (dbg_rn==0) ? 0 : r[dbg_rn]
- rna==rnb is legal; both ports return the same value.
- Counter: wb_cnt wraps modulo 2^CNT_W (all-ones + 1 = 0). It has no saturation.
- Back-to-back writes to the same index: the last edge wins. Each committed write increments wb_cnt.
- Read-during-write to the same index (wb_rn==rna, wb_wreg=1, no bypass): qa shows the old value until the edge, then the new value.
- No X propagation: every register must have a defined reset value.

Optional Feature:
- Macro: WB_BYPASS_EN.
- When defined, ports A and B use internal write-through bypass. If clrn=1, wb_wreg=1, wb_rn!=0 and wb_rn==rna, then qa=wdata in the same cycle, before the edge. Port B behaves identically using rnb. This removes the need for a WB->ID forwarding path.
- dbg_q is never bypassed.
- When not defined, qa and qb return stored array contents only. The old value is visible until the commit edge, and the hazard unit must stall one cycle.

Test Plan:
1. Reset: clrn=0 mid-run after writes r5=0x1234 and wb_cnt=3 -> immediately qa(rna=5)=0, dbg_q=0, wb_cnt=0; reads stay 0 after release until rewritten.
2. ALU vs memory select:
   - wb_wreg=1, wb_m2reg=0, wb_alu=0xDEADBEEF, wb_mo=0x11111111, wb_rn=7, one edge -> dbg_rn=7 gives 0xDEADBEEF.
   - Repeat with wb_m2reg=1 -> 0x11111111; wb_cnt=2.
3. r0 protection: wb_wreg=1, wb_rn=0, wb_alu=0xFFFFFFFF over 3 edges -> qa(rna=0)=0, qb(rnb=0)=0, wb_cnt unchanged.
4. Read-during-write: r9=0xA, then same cycle wb_rn=9, wb_alu=0xB, wb_wreg=1, rna=rnb=9:
   - With WB_BYPASS_EN: qa=qb=0xB before the edge.
   - Without WB_BYPASS_EN: qa=qb=0xA before the edge, 0xB after it.
   - dbg_q(9)=0xA before the edge in both builds.
5. wb_wreg=0 gating: wb_rn=3, wb_alu=0x55, wb_wreg=0 for 4 edges -> r3 keeps its prior value, wb_cnt unchanged, no bypass to qa(rna=3).
6. Counter wrap: CNT_W=4 build, 17 committed writes to r1..r17 after reset -> wb_cnt=1; 0xF followed by a commit reads 0x0.
